// File: rtl/matmul_stream_if.sv
// Handshake and data bundle between the stream host, the matmul engine and the result consumer.
interface matmul_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_W      = 6
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DIM_W-1:0]      cfg_rows1;
  logic [DIM_W-1:0]      cfg_cols1;
  logic [DIM_W-1:0]      cfg_rows2;
  logic [DIM_W-1:0]      cfg_cols2;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;

  modport master (
    output cfg_valid, cfg_rows1, cfg_cols1, cfg_rows2, cfg_cols2,
    output in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_last, done, err, err_code
  );

  modport slave (
    input  cfg_valid, cfg_rows1, cfg_cols1, cfg_rows2, cfg_cols2,
    input  in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_last, done, err, err_code
  );
endinterface

// File: rtl/matmul_stream_engine.sv
// Streaming signed matrix multiplier C = A x B with per-job shapes and shape rejection.
// States: IDLE wait cfg | LOAD_A/LOAD_B stream A,B | MAC one product per cycle | OUT hold C element
module matmul_stream_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_N      = 32,
  parameter int MAX_M      = 32,
  parameter int MAX_Q      = 32,
  parameter int ACC_WIDTH  = 42,
  parameter int SATURATE   = 0,
  parameter int DIM_W      = 6
) (
  input  logic           clk,
  input  logic           reset,
  matmul_stream_if.slave bus
);
  localparam int NA = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int MA = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int QA = (MAX_Q > 1) ? $clog2(MAX_Q) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MAC, OUT} state_t;

  state_t                       state_q, state_d;
  logic [DIM_W-1:0]             i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DIM_W-1:0]             n_q, n_d, m_q, m_d, q_q, q_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic                         out_last_q, out_last_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic [1:0]                   err_code_q, err_code_d;

  logic signed [DATA_WIDTH-1:0] a_mem [MAX_N][MAX_M];
  logic signed [DATA_WIDTH-1:0] b_mem [MAX_M][MAX_Q];

  logic                         in_ready, in_hs, too_big;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic [DATA_WIDTH-1:0]        result;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign in_hs    = in_ready && bus.in_valid;

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

  // Element storage is deliberately not reset; every job overwrites what it reads.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      if (state_q == LOAD_A) a_mem[i_q[NA-1:0]][k_q[MA-1:0]] <= bus.in_data;
      else                   b_mem[k_q[MA-1:0]][j_q[QA-1:0]] <= bus.in_data;
    end
  end

  assign prod    = a_mem[i_q[NA-1:0]][k_q[MA-1:0]] * b_mem[k_q[MA-1:0]][j_q[QA-1:0]];
  assign acc_sum = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign too_big = (bus.cfg_rows1 > DIM_W'(MAX_N)) || (bus.cfg_cols1 > DIM_W'(MAX_M)) ||
                   (bus.cfg_rows2 > DIM_W'(MAX_M)) || (bus.cfg_cols2 > DIM_W'(MAX_Q));

  always_comb begin
    result = acc_sum[DATA_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (acc_sum > SAT_MAX)      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (acc_sum < SAT_MIN) result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    n_d        = n_q;
    m_d        = m_q;
    q_d        = q_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          n_d        = bus.cfg_rows1;
          m_d        = bus.cfg_cols1;
          q_d        = bus.cfg_cols2;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          if (too_big) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
            done_d     = 1'b1;
          end else if (bus.cfg_cols1 != bus.cfg_rows2) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            done_d     = 1'b1;
          end else if (bus.cfg_rows1 == '0 || bus.cfg_cols1 == '0 || bus.cfg_cols2 == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        if (in_hs) begin
          if (k_q == m_q - ONE) begin
            k_d = '0;
            if (i_q == n_q - ONE) begin
              i_d     = '0;
              state_d = LOAD_B;
            end else begin
              i_d = i_q + ONE;
            end
          end else begin
            k_d = k_q + ONE;
          end
        end
      end
      LOAD_B: begin
        if (in_hs) begin
          if (j_q == q_q - ONE) begin
            j_d = '0;
            if (k_q == m_q - ONE) begin
              k_d     = '0;
              acc_d   = '0;
              state_d = MAC;
            end else begin
              k_d = k_q + ONE;
            end
          end else begin
            j_d = j_q + ONE;
          end
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (k_q == m_q - ONE) begin
          out_data_d = result;
          out_last_d = (i_q == n_q - ONE) && (j_q == q_q - ONE);
          state_d    = OUT;
        end else begin
          k_d = k_q + ONE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          acc_d      = '0;
          k_d        = '0;
          out_last_d = 1'b0;
          if (out_last_q) begin
            i_d     = '0;
            j_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MAC;
            if (j_q == q_q - ONE) begin
              j_d = '0;
              i_d = i_q + ONE;
            end else begin
              j_d = j_q + ONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      m_q        <= '0;
      q_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      n_q        <= n_d;
      m_q        <= m_d;
      q_q        <= q_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end
endmodule

// File: tb/tb_matmul_stream_engine.sv
// Bench for matmul_stream_engine: wrap and saturate instances driven in lockstep against a plain-arithmetic model.
module tb_matmul_stream_engine;
  localparam int DW   = 16;
  localparam int DIMW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            cfg_valid;
  logic [DIMW-1:0] r1, c1, r2, c2;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            out_ready;

  matmul_stream_if #(.DATA_WIDTH(DW), .DIM_W(DIMW)) if0 ();
  matmul_stream_if #(.DATA_WIDTH(DW), .DIM_W(DIMW)) if1 ();

  assign if0.cfg_valid = cfg_valid;
  assign if0.cfg_rows1 = r1;
  assign if0.cfg_cols1 = c1;
  assign if0.cfg_rows2 = r2;
  assign if0.cfg_cols2 = c2;
  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.cfg_valid = cfg_valid;
  assign if1.cfg_rows1 = r1;
  assign if1.cfg_cols1 = c1;
  assign if1.cfg_rows2 = r2;
  assign if1.cfg_cols2 = c2;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;

  matmul_stream_engine #(.SATURATE(0)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  matmul_stream_engine #(.SATURATE(1)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ma [32][32];
  int mb [32][32];
  int expq0[$], expq1[$];
  bit lastq0[$], lastq1[$];
  int seen0[$], seen1[$];

  int exp_valid_cyc = -1;
  int last_hs_cyc   = -1;
  bit prev_v        = 1'b0;
  bit bp_rand       = 1'b0;
  bit drop_arm      = 1'b0;
  int drop_cnt      = 0;
  int cur_m         = 1;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Output scoreboard: every valid cycle must present the model's head element.
  always @(negedge clk) begin
    if (!rst) begin
      if (if0.out_valid) begin
        if (expq0.size() == 0) chk("dut0 unexpected out_valid", 1, 0);
        else begin
          chk("dut0 out_data", sx(if0.out_data), expq0[0]);
          chk("dut0 out_last", if0.out_last, lastq0[0]);
          if (out_ready) begin
            seen0.push_back(sx(if0.out_data));
            void'(expq0.pop_front());
            void'(lastq0.pop_front());
          end
        end
      end
      if (if1.out_valid) begin
        if (expq1.size() == 0) chk("dut1 unexpected out_valid", 1, 0);
        else begin
          chk("dut1 out_data", sx(if1.out_data), expq1[0]);
          chk("dut1 out_last", if1.out_last, lastq1[0]);
          if (out_ready) begin
            seen1.push_back(sx(if1.out_data));
            void'(expq1.pop_front());
            void'(lastq1.pop_front());
          end
        end
      end
      if (if0.out_valid && !prev_v && exp_valid_cyc >= 0)
        chk("out_valid latency", cyc, exp_valid_cyc);
      if (if0.out_valid && out_ready) begin
        last_hs_cyc   = cyc;
        exp_valid_cyc = cyc + cur_m + 1;
      end
      prev_v = if0.out_valid && !out_ready;
    end
  end

  always @(posedge clk) begin
    #1;
    if (drop_cnt > 0) begin
      out_ready = 1'b0;
      drop_cnt--;
    end else if (drop_arm && seen0.size() == 1 && if0.out_valid) begin
      drop_arm  = 1'b0;
      drop_cnt  = 4;
      out_ready = 1'b0;
    end else begin
      out_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_cfg(input int a, input int b, input int c, input int d);
    cfg_valid = 1'b1;
    r1 = DIMW'(a);
    c1 = DIMW'(b);
    r2 = DIMW'(c);
    c2 = DIMW'(d);
    @(negedge clk);
    chk("cfg_ready before accept", if0.cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_elem(input int v, output int hcyc);
    hcyc = -1;
    if (bp_rand && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = DW'(v);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (if0.in_ready) begin
        hcyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("in_ready timeout", 0, 1);
  endtask

  task automatic job(input int n, input int m, input int rr2, input int q);
    int     code, h, found;
    bit     empty;
    longint acc;
    logic [DW-1:0] lo;
    code  = (n > 32 || m > 32 || rr2 > 32 || q > 32) ? 2 : (m != rr2) ? 1 : 0;
    empty = (code == 0) && (n == 0 || m == 0 || q == 0);
    seen0.delete();
    seen1.delete();
    if (code == 0 && !empty) begin
      for (int i = 0; i < n; i++)
        for (int j = 0; j < q; j++) begin
          acc = 0;
          for (int k = 0; k < m; k++) acc += longint'(ma[i][k]) * longint'(mb[k][j]);
          lo = acc[DW-1:0];
          expq0.push_back(int'($signed(lo)));
          expq1.push_back(acc > 32767 ? 32767 : (acc < -32768 ? -32768 : int'(acc)));
          lastq0.push_back(i == n - 1 && j == q - 1);
          lastq1.push_back(i == n - 1 && j == q - 1);
        end
      cur_m = m;
    end
    send_cfg(n, m, rr2, q);
    if (code != 0 || empty) begin
      @(negedge clk);
      chk("reject done", if0.done, 1);
      chk("reject done sat", if1.done, 1);
      chk("reject err", if0.err, code != 0);
      chk("reject err_code", if0.err_code, code);
      chk("reject in_ready", if0.in_ready, 0);
      chk("reject cfg_ready", if0.cfg_ready, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("reject done width", if0.done, 0);
      chk("reject err sticky", if0.err, code != 0);
      chk("reject out_valid", if0.out_valid, 0);
      @(posedge clk); #1;
      return;
    end
    @(negedge clk);
    chk("accept err cleared", if0.err, 0);
    chk("accept err_code", if0.err_code, 0);
    chk("accept done", if0.done, 0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < m; k++) send_elem(ma[i][k], h);
    for (int k = 0; k < m; k++)
      for (int j = 0; j < q; j++) send_elem(mb[k][j], h);
    if (h >= 0) exp_valid_cyc = h + m + 1;
    @(negedge clk);
    chk("in_ready drop after last B", if0.in_ready, 0);
    found = 0;
    for (int t = 0; t < 40000; t++) begin
      @(negedge clk);
      if (if0.done) begin
        found = 1;
        break;
      end
    end
    chk("done seen", found, 1);
    if (found == 1) begin
      chk("done timing", cyc, last_hs_cyc + 1);
      chk("done sat", if1.done, 1);
      chk("cfg_ready with done", if0.cfg_ready, 1);
      chk("outputs drained", expq0.size() + expq1.size(), 0);
      chk("err after job", if0.err, 0);
    end
    @(posedge clk); #1;
    exp_valid_cyc = -1;
  endtask

  int lit22[4] = '{19, 22, 43, 50};
  int hdummy;

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    r1 = '0; c1 = '0; r2 = '0; c2 = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cfg_ready", if0.cfg_ready, 1);
    chk("rst in_ready", if0.in_ready, 0);
    chk("rst out_valid", if0.out_valid, 0);
    chk("rst out_last", if0.out_last, 0);
    chk("rst done", if0.done, 0);
    chk("rst err", if0.err, 0);
    chk("rst err_code", if0.err_code, 0);
    chk("rst out_data", 64'(if0.out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    ma[0][0] = 2; mb[0][0] = 3;
    job(1, 1, 1, 1);
    chk("1x1 count", seen0.size(), 1);
    if (seen0.size() == 1) chk("1x1 value", seen0[0], 6);

    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    job(2, 2, 2, 2);
    chk("2x2 count", seen0.size(), 4);
    for (int x = 0; x < 4 && x < seen0.size(); x++) chk("2x2 value", seen0[x], lit22[x]);

    job(10, 10, 5, 5);
    job(33, 4, 4, 4);
    ma[0][0] = -7; mb[0][0] = 9;
    job(1, 1, 1, 1);
    if (seen0.size() == 1) chk("clear-err 1x1 value", seen0[0], -63);
    job(0, 0, 0, 0);
    job(2, 0, 0, 3);

    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    drop_arm = 1'b1;
    job(2, 2, 2, 2);
    chk("bp 2x2 count", seen0.size(), 4);
    for (int x = 0; x < 4 && x < seen0.size(); x++) chk("bp 2x2 value", seen0[x], lit22[x]);

    send_cfg(2, 2, 2, 2);
    for (int x = 0; x < 5; x++) send_elem(x + 1, hdummy);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-reset cfg_ready", if0.cfg_ready, 1);
    chk("mid-reset in_ready", if0.in_ready, 0);
    chk("mid-reset done", if0.done, 0);
    chk("mid-reset out_valid", if0.out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid-reset no late done", if0.done, 0);
    @(posedge clk); #1;
    ma[0][0] = 2; mb[0][0] = 3;
    job(1, 1, 1, 1);
    if (seen0.size() == 1) chk("post-reset 1x1 value", seen0[0], 6);

    bp_rand = 1'b1;
    for (int t = 0; t < 10; t++) begin
      int n, m, q;
      n = $urandom_range(1, 4);
      m = $urandom_range(1, 4);
      q = $urandom_range(1, 4);
      for (int i = 0; i < 32; i++)
        for (int k = 0; k < 32; k++) begin
          ma[i][k] = int'($urandom_range(0, 65535)) - 32768;
          mb[i][k] = int'($urandom_range(0, 65535)) - 32768;
        end
      job(n, m, m, q);
    end
    bp_rand = 1'b0;

    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 32; k++) begin
        ma[i][k] = 32767;
        mb[i][k] = 32767;
      end
    job(32, 32, 32, 32);
    chk("32x32 count wrap", seen0.size(), 1024);
    chk("32x32 count sat", seen1.size(), 1024);
    if (seen0.size() > 0) chk("32x32 wrap value", seen0[0], 32);
    if (seen1.size() > 0) chk("32x32 sat value", seen1[seen1.size() - 1], 32767);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
